video_pattern_gen: RTL and testbench

- Synthesizable, parametrised video source that produces VGA-style input timing (frame sync pulse, line sync pulse, pixel enable, pixel data) for the scaler's input port.
- Used for on-chip bring-up and for simulation stimulus.
- Adds programmable blanking, four pattern modes, a frame count, pixel-hold backpressure and abort.
- Resolution, mode and frame count are latched at start; a run is unaffected by input changes.

---
 rtl/video_pattern_gen_pkg.sv | 22 ++
 rtl/video_pattern_gen_lut.sv | 38 +++
 rtl/video_pattern_gen.sv | 205 ++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the video pattern generator: mode and state encodings
// plus the default pixel and resolution widths that the scaler also uses.
package video_pattern_gen_pkg;

  localparam int DEF_DATA_WIDTH      = 24;
  localparam int DEF_INPUT_RES_WIDTH = 11;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_COORD = 2'd1;
  localparam logic [1:0] MODE_CHK   = 2'd2;
  localparam logic [1:0] MODE_BARS  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/video_pattern_gen_lut.sv
// Combinational pattern table: maps pixel coordinate, ramp value and mode to a
// pixel. New patterns go here without touching the timing FSM.
module video_pattern_gen_lut
  import video_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int INPUT_RES_WIDTH = DEF_INPUT_RES_WIDTH,
  parameter int CHK_LOG2        = 3,
  parameter int BAR_SHIFT       = 4
) (
  input  logic [INPUT_RES_WIDTH-1:0] x,
  input  logic [INPUT_RES_WIDTH-1:0] y,
  input  logic [DATA_WIDTH-1:0]      seq,
  input  logic [1:0]                 mode,
  output logic [DATA_WIDTH-1:0]      pattern
);

  localparam int FIELD_W = DATA_WIDTH / 3;

  logic       chkOn;
  logic [2:0] bar;

  assign chkOn = x[CHK_LOG2] ^ y[CHK_LOG2];
  assign bar   = 3'(x >> BAR_SHIFT);

  always_comb begin
    pattern = '0;
    case (mode)
      MODE_RAMP:  pattern = seq;
      // Size cast zero-extends or drops MSBs of {y,x} to fit the pixel.
      MODE_COORD: pattern = DATA_WIDTH'({y, x});
      MODE_CHK:   pattern = {DATA_WIDTH{chkOn}};
      MODE_BARS:  pattern = {{FIELD_W{bar[2]}}, {FIELD_W{bar[1]}}, {FIELD_W{bar[0]}}};
      default:    pattern = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// VGA-style test source: frame/line sync, pixel enable and pattern data with
// programmable blanking, frame count, pixel-hold backpressure and abort.
module video_pattern_gen
  import video_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int INPUT_RES_WIDTH = DEF_INPUT_RES_WIDTH,
  parameter int HBLANK_LEN      = 4,
  parameter int VBLANK_LEN      = 2,
  parameter int CHK_LOG2        = 3,
  parameter int BAR_SHIFT       = 4
) (
  input  logic                       clka,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [7:0]                 frames,
  input  logic [INPUT_RES_WIDTH-1:0] inXRes,
  input  logic [INPUT_RES_WIDTH-1:0] inYRes,
  input  logic                       hold,
  output logic [DATA_WIDTH-1:0]      dOut,
  output logic                       dOutEn,
  output logic                       oHsyn,
  output logic                       oVsyn,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [7:0]                 frame_cnt
);

  localparam int BLANK_MAX = (HBLANK_LEN > VBLANK_LEN) ? HBLANK_LEN : VBLANK_LEN;
  localparam int BLANK_W   = $clog2(BLANK_MAX + 1);
  localparam logic [BLANK_W-1:0] H_END = BLANK_W'(HBLANK_LEN - 1);
  localparam logic [BLANK_W-1:0] V_END = BLANK_W'(VBLANK_LEN - 1);

  if (DATA_WIDTH % 3 != 0) begin : gDataWidthChk
    $error("DATA_WIDTH must be a multiple of 3");
  end
  if (HBLANK_LEN < 1 || VBLANK_LEN < 1) begin : gBlankChk
    $error("HBLANK_LEN and VBLANK_LEN must be at least 1");
  end

  state_t                     state, stateNxt;
  logic [1:0]                 modeL, modeNxt;
  logic [7:0]                 framesL, framesNxt;
  logic [INPUT_RES_WIDTH-1:0] xResL, xResNxt, yResL, yResNxt;
  logic [INPUT_RES_WIDTH-1:0] xCnt, xNxt, yCnt, yNxt;
  logic [DATA_WIDTH-1:0]      seqCnt, seqNxt, seqInc, pixel;
  logic [BLANK_W-1:0]         blankCnt, blankNxt;
  logic [DATA_WIDTH-1:0]      dOutNxt;
  logic                       dOutEnNxt, oHsynNxt, oVsynNxt, busyNxt, doneNxt, errNxt;
  logic [7:0]                 frameCntNxt, frameInc;
  logic                       startOk, xLast, yLast, runEnd;

  // xCnt is the next pixel to emit, so it equals xResL right after the last one.
  assign startOk  = (inXRes != '0) && (inYRes != '0);
  assign xLast    = (xCnt == xResL);
  assign yLast    = (yCnt == yResL - 1'b1);
  assign frameInc = frame_cnt + 1'b1;
  assign runEnd   = (framesL != '0) && (frameInc == framesL);
  assign seqInc   = seqCnt + 1'b1;

  video_pattern_gen_lut #(
    .DATA_WIDTH      (DATA_WIDTH),
    .INPUT_RES_WIDTH (INPUT_RES_WIDTH),
    .CHK_LOG2        (CHK_LOG2),
    .BAR_SHIFT       (BAR_SHIFT)
  ) uLut (
    .x       (xCnt),
    .y       (yCnt),
    .seq     (seqInc),
    .mode    (modeL),
    .pattern (pixel)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      modeL     <= '0;
      framesL   <= '0;
      xResL     <= '0;
      yResL     <= '0;
      xCnt      <= '0;
      yCnt      <= '0;
      seqCnt    <= '0;
      blankCnt  <= '0;
      dOut      <= '0;
      dOutEn    <= 1'b0;
      oHsyn     <= 1'b0;
      oVsyn     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= stateNxt;
      modeL     <= modeNxt;
      framesL   <= framesNxt;
      xResL     <= xResNxt;
      yResL     <= yResNxt;
      xCnt      <= xNxt;
      yCnt      <= yNxt;
      seqCnt    <= seqNxt;
      blankCnt  <= blankNxt;
      dOut      <= dOutNxt;
      dOutEn    <= dOutEnNxt;
      oHsyn     <= oHsynNxt;
      oVsyn     <= oVsynNxt;
      busy      <= busyNxt;
      done      <= doneNxt;
      err       <= errNxt;
      frame_cnt <= frameCntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    if (!en) begin
      stateNxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start && startOk) stateNxt = ST_VSYNC;
        ST_VSYNC:  stateNxt = ST_ACTIVE;
        ST_ACTIVE: if (dOutEn && xLast) stateNxt = yLast ? ST_VBLANK : ST_HBLANK;
        ST_HBLANK: if (blankCnt == H_END) stateNxt = ST_ACTIVE;
        ST_VBLANK: if (blankCnt == V_END) stateNxt = runEnd ? ST_DONE : ST_VSYNC;
        ST_DONE:   stateNxt = ST_IDLE;
        default:   stateNxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered, so this computes the values for the cycle being entered.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    dOutNxt     = dOut;
    dOutEnNxt   = 1'b0;
    oHsynNxt    = 1'b0;
    oVsynNxt    = 1'b0;
    busyNxt     = 1'b0;
    doneNxt     = 1'b0;
    errNxt      = 1'b0;
    frameCntNxt = frame_cnt;
    xNxt        = xCnt;
    yNxt        = yCnt;
    seqNxt      = seqCnt;
    blankNxt    = blankCnt;
    modeNxt     = modeL;
    framesNxt   = framesL;
    xResNxt     = xResL;
    yResNxt     = yResL;

    if (en && state == ST_IDLE && start) begin
      if (startOk) begin
        modeNxt     = mode;
        framesNxt   = frames;
        xResNxt     = inXRes;
        yResNxt     = inYRes;
        seqNxt      = '0;
        frameCntNxt = '0;
      end else begin
        errNxt = 1'b1;
      end
    end
    if (en && state == ST_VBLANK && blankCnt == V_END) frameCntNxt = frameInc;

    case (stateNxt)
      ST_VSYNC: begin
        oVsynNxt = 1'b1;
        busyNxt  = 1'b1;
        xNxt     = '0;
        yNxt     = '0;
      end
      ST_ACTIVE: begin
        busyNxt = 1'b1;
        if (!hold) begin
          dOutNxt   = pixel;
          dOutEnNxt = 1'b1;
          xNxt      = xCnt + 1'b1;
          seqNxt    = seqInc;
        end
      end
      ST_HBLANK: begin
        busyNxt = 1'b1;
        if (state != ST_HBLANK) begin
          oHsynNxt = 1'b1;
          blankNxt = '0;
          xNxt     = '0;
          yNxt     = yCnt + 1'b1;
        end else begin
          blankNxt = blankCnt + 1'b1;
        end
      end
      ST_VBLANK: begin
        busyNxt  = 1'b1;
        blankNxt = (state != ST_VBLANK) ? '0 : blankCnt + 1'b1;
      end
      ST_DONE: doneNxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: cycle-exact timing of a small
// frame plus a pixel scoreboard fed with expected values before each run.
module tb_video_pattern_gen;

  logic        clka;
  logic        rst;
  logic        en;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  frames;
  logic [10:0] inXRes;
  logic [10:0] inYRes;
  logic        hold;
  logic [23:0] dOut;
  logic        dOutEn;
  logic        oHsyn;
  logic        oVsyn;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  frame_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] sbQ[$];
  logic        sbOn;

  video_pattern_gen #(
    .DATA_WIDTH      (24),
    .INPUT_RES_WIDTH (11),
    .HBLANK_LEN      (4),
    .VBLANK_LEN      (2),
    .CHK_LOG2        (3),
    .BAR_SHIFT       (4)
  ) dut (
    .clka      (clka),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .mode      (mode),
    .frames    (frames),
    .inXRes    (inXRes),
    .inYRes    (inYRes),
    .hold      (hold),
    .dOut      (dOut),
    .dOutEn    (dOutEn),
    .oHsyn     (oHsyn),
    .oVsyn     (oVsyn),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every valid pixel must match the oldest expected value.
  always @(negedge clka) begin
    if (sbOn && dOutEn) begin
      if (sbQ.size() == 0) check("sb_extra_pixel", {8'h0, dOut}, 32'hFFFF_FFFF);
      else check("sb_pixel", {8'h0, dOut}, {8'h0, sbQ.pop_front()});
    end
  end

  task automatic nextCyc();
    @(negedge clka);
  endtask

  // Returns at the sample point of the first cycle after the start edge.
  // Inputs are scrambled afterwards to show the run uses latched values.
  task automatic startRun(input logic [1:0] m, input logic [7:0] f,
                          input logic [10:0] xr, input logic [10:0] yr);
    mode   = m;
    frames = f;
    inXRes = xr;
    inYRes = yr;
    start  = 1'b1;
    @(posedge clka);
    @(negedge clka);
    start  = 1'b0;
    mode   = ~m;
    frames = 8'hAA;
    inXRes = 11'd5;
    inYRes = 11'd7;
  endtask

  task automatic waitDone(input int budget, output int vsCnt);
    int n;
    n     = 0;
    vsCnt = 0;
    while (!done && n < budget) begin
      if (oVsyn) vsCnt++;
      nextCyc();
      n++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  function automatic logic [23:0] barsExp(input int x);
    logic [2:0] b;
    b = 3'((x >> 4) & 7);
    return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  function automatic logic [23:0] chkExp(input int x, input int y);
    return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
  endfunction

  initial begin
    int       vs;
    int       pulses;
    logic [4:0] expCtl;
    rst    = 1'b0;
    en     = 1'b0;
    start  = 1'b0;
    hold   = 1'b0;
    mode   = 2'd0;
    frames = 8'd0;
    inXRes = '0;
    inYRes = '0;
    sbOn   = 1'b0;

    repeat (3) nextCyc();
    check("rst_dout", {8'h0, dOut}, 32'd0);
    check("rst_ctl", {26'b0, dOutEn, oHsyn, oVsyn, busy, done, err}, 32'd0);
    check("rst_fcnt", {24'b0, frame_cnt}, 32'd0);
    rst = 1'b1;
    en  = 1'b1;
    nextCyc();

    // 3x3 ramp, one frame, cycle-exact control timing {oVsyn,oHsyn,dOutEn,done,busy}
    sbOn = 1'b1;
    for (int i = 1; i <= 9; i++) sbQ.push_back(24'(i));
    startRun(2'd0, 8'd1, 11'd3, 11'd3);
    for (int k = 1; k <= 21; k++) begin
      if (k > 1) nextCyc();
      expCtl[4] = (k == 1);
      expCtl[3] = (k == 5) || (k == 12);
      expCtl[2] = (k >= 2 && k <= 4) || (k >= 9 && k <= 11) || (k >= 16 && k <= 18);
      expCtl[1] = (k == 21);
      expCtl[0] = (k <= 20);
      check($sformatf("t1_ctl_c%0d", k), {27'b0, oVsyn, oHsyn, dOutEn, done, busy},
            {27'b0, expCtl});
    end
    check("t1_fcnt", {24'b0, frame_cnt}, 32'd1);
    check("t1_sb_left", sbQ.size(), 32'd0);

    // Three frames: ramp continues 1..27 across frames
    nextCyc();
    for (int i = 1; i <= 27; i++) sbQ.push_back(24'(i));
    startRun(2'd0, 8'd3, 11'd3, 11'd3);
    waitDone(300, vs);
    check("t3_vsync_cnt", vs, 32'd3);
    check("t3_fcnt", {24'b0, frame_cnt}, 32'd3);
    check("t3_sb_left", sbQ.size(), 32'd0);

    // Coordinate mode 4x2 with a two-cycle hold mid-line
    nextCyc();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) sbQ.push_back(24'((y << 11) + x));
    startRun(2'd1, 8'd1, 11'd4, 11'd2);
    nextCyc();
    nextCyc();
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      nextCyc();
      check("t4_hold_en", {31'b0, dOutEn}, 32'd0);
      check("t4_hold_dout", {8'h0, dOut}, 32'd1);
    end
    hold = 1'b0;
    waitDone(100, vs);
    check("t4_sb_left", sbQ.size(), 32'd0);

    // Colour bars across 128 pixels, one line
    nextCyc();
    for (int x = 0; x < 128; x++) sbQ.push_back(barsExp(x));
    startRun(2'd3, 8'd1, 11'd128, 11'd1);
    for (int x = 0; x < 128; x++) begin
      nextCyc();
      if (x == 0)   check("t5_bar_x0", {8'h0, dOut}, 32'h000000);
      if (x == 16)  check("t5_bar_x16", {8'h0, dOut}, 32'h0000FF);
      if (x == 112) check("t5_bar_x112", {8'h0, dOut}, 32'hFFFFFF);
    end
    waitDone(20, vs);
    check("t5_sb_left", sbQ.size(), 32'd0);

    // Checkerboard 16x16
    nextCyc();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) sbQ.push_back(chkExp(x, y));
    startRun(2'd2, 8'd1, 11'd16, 11'd16);
    waitDone(600, vs);
    check("t6_sb_left", sbQ.size(), 32'd0);

    // Continuous run aborted mid-line, then a rejected start
    nextCyc();
    sbOn = 1'b0;
    startRun(2'd0, 8'd0, 11'd4, 11'd4);
    nextCyc();
    nextCyc();
    check("ab_pix2", {8'h0, dOut}, 32'd2);
    en = 1'b0;
    nextCyc();
    check("ab_ctl", {28'b0, dOutEn, busy, done, oHsyn}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) en = 1'b1;
      nextCyc();
      if (done || busy || dOutEn) pulses++;
    end
    check("ab_idle", pulses, 32'd0);
    startRun(2'd0, 8'd1, 11'd4, 11'd0);
    check("err_pulse", {31'b0, err}, 32'd1);
    check("err_idle", {30'b0, busy, oVsyn}, 32'd0);
    nextCyc();
    check("err_clear", {29'b0, err, busy, oVsyn}, 32'd0);

    // Asynchronous reset mid-frame, then a fresh run restarts the ramp at 1
    nextCyc();
    startRun(2'd0, 8'd0, 11'd3, 11'd3);
    repeat (3) nextCyc();
    @(posedge clka);
    #2;
    rst = 1'b0;
    #1;
    check("arst_dout", {8'h0, dOut}, 32'd0);
    check("arst_ctl", {26'b0, dOutEn, oHsyn, oVsyn, busy, done, err}, 32'd0);
    check("arst_fcnt", {24'b0, frame_cnt}, 32'd0);
    @(negedge clka);
    rst = 1'b1;
    nextCyc();
    sbOn = 1'b1;
    for (int i = 1; i <= 9; i++) sbQ.push_back(24'(i));
    startRun(2'd0, 8'd1, 11'd3, 11'd3);
    waitDone(100, vs);
    check("arst_fcnt_run", {24'b0, frame_cnt}, 32'd1);
    check("arst_sb_left", sbQ.size(), 32'd0);

    nextCyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
